sevenseg_capture: RTL and testbench
===================================

Name: sevenseg_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Snoops a multiplexed, active-low 7-segment display bus (segment lines plus one-hot-low anode enables). It reconstructs the hex nibble shown on each digit and holds it in registers.
- Used for display loopback self-test and for bench/ILA observation of what the display driver actually emits.
- Each sample is accepted only after it has been stable for a programmable dwell, which rejects scan-transition ghosting.

Parameters:
- NUM_DIGITS, 8: number of anode lines / digit slots; range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a commit; minimum 2.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- seg_in  input  7  segment lines, active-low; bit0=a ... bit6=g.
- an_in  input  NUM_DIGITS  anode enables, active-low, one-hot-low when a digit is driven.
- digits_out  output  4*NUM_DIGITS  captured nibble per digit; digit i occupies bits [4i+3:4i].
- valid_out  output  NUM_DIGITS  digit i holds a legally decoded value.
- err_out  output  NUM_DIGITS  last commit to digit i was an illegal segment pattern.
- multi_an_out  output  1  sticky flag: more than one anode was low in some sample.
- update_out  output  1  one-cycle pulse on each commit.
- update_idx_out  output  3  digit index of the current/last commit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n_in), with clk_in as the clock. During reset, all outputs and registers are 0 and the FSM is in IDLE.
- Input sampling: seg_in and an_in are registered once per clock into the sample register (sample_q).
- Decode table (active-low, g..a): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E. Every other pattern, including blank 0x7F, is illegal.
- Anode classification of sample_q:
  - no bit low: idle;
  - exactly one bit low: digit index i;
  - more than one bit low: multi; sets multi_an_out (cleared only by reset) and is treated as idle.
- FSM IDLE:
  - idle or multi sample: stay in IDLE.
  - single-digit sample: go to TRACK, cnt=1, latch the (an, seg) pair as ref.
- FSM TRACK:
  - sample equals ref: cnt++.
  - sample differs but is single-digit: re-latch ref, cnt=1.
  - idle or multi sample: go to IDLE.
  - cnt reaches STABLE_CYCLES: commit, go to HELD.
- FSM HELD:
  - stay while sample equals ref; no re-commit.
  - single-digit change: go to TRACK with cnt=1.
  - idle or multi: go to IDLE.
- Commit, legal pattern: digits_out[i] <= nibble, valid_out[i] <= 1, err_out[i] <= 0.
- Commit, illegal pattern: digits_out[i] unchanged, valid_out[i] <= 0, err_out[i] <= 1.
- Every commit: update_out=1 for exactly one cycle; update_idx_out=i, held until the next commit.
- Latency: for a pair applied at edge 0 and held, update_out is high in the cycle after edge STABLE_CYCLES; the digit registers update on that same edge.
- Width rule: cnt is $clog2(STABLE_CYCLES+1) bits and saturates; it never wraps.
- Boundary cases:
  - A pair held indefinitely commits exactly once.
  - A change at the cnt=STABLE_CYCLES-1 sample restarts the count; no commit occurs.
  - The same digit re-shown after another digit re-commits (a fresh dwell).
- Reset mid-dwell clears all captured state; no partial commit survives.

Optional Feature:
- SEVENSEG_CAPTURE_SYNC_EN
- Defined: seg_in and an_in pass through a 2-flop synchronizer ahead of sample_q, for pins driven from another clock domain or from off-chip. Commit latency grows by 2 cycles. Synchronizer flops reset to 1 (bus inactive).
- Undefined: inputs feed sample_q directly.
- All other behaviour is identical in both builds.

Decomposition:
- sevenseg_pkg: the 16 segment pattern constants (active-low, shared with the encoder), the SEG_BLANK constant 7'h7F, and the FSM state enum (IDLE, TRACK, HELD).
- Sub-module s7tob: purely combinational; seg[6:0] in, nibble[3:0] and legal out. It is the table inverse of the encoder and can be checked exhaustively against it.

Test Plan:
- Exhaustive decode: for each x in 0..15, drive seg_in=encoder(x), an_in=0xFE for 4 cycles. Required: digits_out[3:0]==x, valid_out[0]=1, exactly one update_out pulse, update_idx_out=0.
- Scan: rotate an_in through 0xFE..0x7F, 6 cycles each, showing digits 1,2,...,8. Required: digits_out=0x87654321, valid_out=0xFF, eight update pulses.
- Glitch: on digit 3, hold 0x24 for 3 cycles then 0x30 for 4 cycles. Required: a single commit with value 3; no commit for the value 2.
- Illegal pattern: seg_in=0x7F on digit 5 with 0x12 previously captured. Required: err_out[5]=1, valid_out[5]=0, digits_out[23:20]=5 (unchanged).
- Multi-anode: an_in=0xFC for 10 cycles. Required: multi_an_out=1, no update_out, state IDLE.
- Reset mid-dwell: assert rst_n_in at cnt=2. Required: all outputs 0 immediately (asynchronously), no commit after release until a full new dwell completes.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment constants (active-low, bit0=a .. bit6=g) and capture FSM states.
// Used by the encoder side and by sevenseg_capture.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry k holds the pattern for nibble k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// Multiplexed active-low 7-segment display bus: segment lines plus one-hot-low anodes.
// master = display driver, slave = passive snooper.
interface sevenseg_capture_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (output seg, output an);
  modport slave  (input  seg, input  an);
endinterface

// File: rtl/sevenseg_capture_s7tob.sv
// s7tob: combinational inverse of the hex-to-7-segment encoder.
// legal is low for any pattern outside the 16-entry table, including blank.
module s7tob
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    if (seg != SEG_BLANK) begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (seg == SEG_TABLE[k]) begin
          nibble = 4'(k);
          legal  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: snoops a multiplexed 7-segment bus and holds the nibble shown per digit.
// Optional `SEVENSEG_CAPTURE_SYNC_EN adds a 2-flop input synchronizer ahead of the sample register.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  sevenseg_capture_if.slave       bus,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    multi_an_out,
  output logic                    update_out,
  output logic [2:0]              update_idx_out
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  logic [6:0]            seg_src;
  logic [NUM_DIGITS-1:0] an_src;

`ifdef SEVENSEG_CAPTURE_SYNC_EN
  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] an_s1, an_s2;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
    end else begin
      seg_s1 <= bus.seg;
      seg_s2 <= seg_s1;
      an_s1  <= bus.an;
      an_s2  <= an_s1;
    end
  end

  assign seg_src = seg_s2;
  assign an_src  = an_s2;
`else
  assign seg_src = bus.seg;
  assign an_src  = bus.an;
`endif

  // Anodes are stored inverted so the all-zero reset value reads as "no digit driven".
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] en_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      seg_q <= '0;
      en_q  <= '0;
    end else begin
      seg_q <= seg_src;
      en_q  <= ~an_src;
    end
  end

  logic       any_en, multi_en, single_en;
  logic [2:0] idx;

  assign any_en    = |en_q;
  assign multi_en  = |(en_q & (en_q - NUM_DIGITS'(1)));
  assign single_en = any_en && !multi_en;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (en_q[i]) idx = 3'(i);
    end
  end

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_DIGITS-1:0] ref_en;
  logic [6:0]            ref_seg;
  logic [2:0]            ref_idx;
  logic                  match;
  logic [3:0]            ref_nibble;
  logic                  ref_legal;

  assign match = (en_q == ref_en) && (seg_q == ref_seg);

  s7tob u_s7tob (
    .seg    (ref_seg),
    .nibble (ref_nibble),
    .legal  (ref_legal)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      ref_en         <= '0;
      ref_seg        <= '0;
      ref_idx        <= '0;
      digits_out     <= '0;
      valid_out      <= '0;
      err_out        <= '0;
      multi_an_out   <= 1'b0;
      update_out     <= 1'b0;
      update_idx_out <= '0;
    end else begin
      update_out <= 1'b0;
      if (multi_en) multi_an_out <= 1'b1;

      unique case (state)
        IDLE: begin
          if (single_en) begin
            state   <= TRACK;
            cnt     <= CNT_ONE;
            ref_en  <= en_q;
            ref_seg <= seg_q;
            ref_idx <= idx;
          end
        end
        TRACK: begin
          if (!single_en) begin
            state <= IDLE;
          end else if (!match) begin
            cnt     <= CNT_ONE;
            ref_en  <= en_q;
            ref_seg <= seg_q;
            ref_idx <= idx;
          end else if (cnt >= CNT_LAST) begin
            // This sample is the STABLE_CYCLES-th identical one: commit now.
            state          <= HELD;
            cnt            <= CNT_MAX;
            update_out     <= 1'b1;
            update_idx_out <= ref_idx;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
              if (ref_idx == 3'(i)) begin
                if (ref_legal) digits_out[4*i +: 4] <= ref_nibble;
                valid_out[i] <= ref_legal;
                err_out[i]   <= !ref_legal;
              end
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!single_en) begin
            state <= IDLE;
          end else if (!match) begin
            state   <= TRACK;
            cnt     <= CNT_ONE;
            ref_en  <= en_q;
            ref_seg <= seg_q;
            ref_idx <= idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: expected commits are queued as stimulus is driven
// and checked against each update_out pulse.
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  localparam int unsigned ND = 8;
  localparam int unsigned SC = 4;
`ifdef SEVENSEG_CAPTURE_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] nib;
    logic       legal;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   updates    = 0;
  int   u0;
  int   lat;
  logic prev_update = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   valid_out;
  logic [ND-1:0]   err_out;
  logic            multi_an_out;
  logic            update_out;
  logic [2:0]      update_idx_out;

  sevenseg_capture_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .bus            (bus),
    .digits_out     (digits_out),
    .valid_out      (valid_out),
    .err_out        (err_out),
    .multi_an_out   (multi_an_out),
    .update_out     (update_out),
    .update_idx_out (update_idx_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int unsigned x);
    case (x)
      0: enc = 7'h40;  1: enc = 7'h79;  2: enc = 7'h24;  3: enc = 7'h30;
      4: enc = 7'h19;  5: enc = 7'h12;  6: enc = 7'h02;  7: enc = 7'h78;
      8: enc = 7'h00;  9: enc = 7'h10; 10: enc = 7'h08; 11: enc = 7'h03;
     12: enc = 7'h46; 13: enc = 7'h21; 14: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_commit(input int unsigned idx, input int unsigned nib, input logic legal);
    exp_t e;
    e.idx   = 3'(idx);
    e.nib   = 4'(nib);
    e.legal = legal;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int unsigned n);
    bus.an  = an;
    bus.seg = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    drive(8'hFF, 7'h7F, n);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (update_out) begin
      updates++;
      check("pulse_width", 32'(prev_update), 32'(0));
      check("commit_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("update_idx", 32'(update_idx_out), 32'(e.idx));
        check("digit_nibble", 32'(digits_out[4*e.idx +: 4]), 32'(e.nib));
        check("valid_bit", 32'(valid_out[e.idx]), 32'(e.legal));
        check("err_bit", 32'(err_out[e.idx]), 32'(!e.legal));
      end
    end
    prev_update = update_out;
  end

  initial begin
    bus.an  = '1;
    bus.seg = 7'h7F;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", digits_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_err", 32'(err_out), 32'h0);
    check("rst_multi", 32'(multi_an_out), 32'h0);
    check("rst_update", 32'(update_out), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    idle(3);

    // Exhaustive decode on digit 0
    u0 = updates;
    for (int unsigned x = 0; x < 16; x++) begin
      expect_commit(0, x, 1'b1);
      drive(8'hFE, enc(x), SC);
    end
    idle(8 + SYNC_LAT);
    check("exh_updates", 32'(updates - u0), 32'd16);
    check("exh_digit0", 32'(digits_out[3:0]), 32'hF);
    check("exh_valid0", 32'(valid_out[0]), 32'h1);
    check("exh_idx", 32'(update_idx_out), 32'h0);

    // Scan all eight digits
    u0 = updates;
    for (int unsigned i = 0; i < 8; i++) begin
      logic [7:0] an;
      an = ~(8'h01 << i);
      expect_commit(i, i + 1, 1'b1);
      drive(an, enc(i + 1), 6);
    end
    idle(8 + SYNC_LAT);
    check("scan_updates", 32'(updates - u0), 32'd8);
    check("scan_digits", digits_out, 32'h87654321);
    check("scan_valid", 32'(valid_out), 32'hFF);

    // Glitch: change lands on the cnt=SC-1 sample
    u0 = updates;
    expect_commit(3, 3, 1'b1);
    drive(8'hF7, 7'h24, 3);
    drive(8'hF7, 7'h30, 4);
    idle(8 + SYNC_LAT);
    check("glitch_updates", 32'(updates - u0), 32'd1);
    check("glitch_digit3", 32'(digits_out[15:12]), 32'h3);

    // Illegal pattern after a legal capture
    u0 = updates;
    expect_commit(5, 5, 1'b1);
    drive(8'hDF, 7'h12, 6);
    expect_commit(5, 5, 1'b0);
    drive(8'hDF, 7'h7F, 6);
    idle(8 + SYNC_LAT);
    check("illegal_updates", 32'(updates - u0), 32'd2);
    check("illegal_err5", 32'(err_out[5]), 32'h1);
    check("illegal_valid5", 32'(valid_out[5]), 32'h0);
    check("illegal_digit5", 32'(digits_out[23:20]), 32'h5);

    // Long hold commits once
    u0 = updates;
    expect_commit(4, 4, 1'b1);
    drive(8'hEF, 7'h19, 40);
    idle(8 + SYNC_LAT);
    check("hold_updates", 32'(updates - u0), 32'd1);

    // Same digit re-shown after another digit
    u0 = updates;
    expect_commit(0, 1, 1'b1);
    drive(8'hFE, 7'h79, 6);
    expect_commit(1, 2, 1'b1);
    drive(8'hFD, 7'h24, 6);
    expect_commit(0, 1, 1'b1);
    drive(8'hFE, 7'h79, 6);
    idle(8 + SYNC_LAT);
    check("reshow_updates", 32'(updates - u0), 32'd3);

    // Multi-anode
    check("multi_before", 32'(multi_an_out), 32'h0);
    u0 = updates;
    drive(8'hFC, 7'h40, 10);
    check("multi_flag", 32'(multi_an_out), 32'h1);
    check("multi_updates", 32'(updates - u0), 32'd0);
    check("multi_state", 32'(dut.state), 32'(IDLE));
    idle(4);
    check("multi_sticky", 32'(multi_an_out), 32'h1);

    // Reset mid-dwell
    drive(8'hFB, 7'h24, 3 + SYNC_LAT);
    rst_n = 1'b0;
    #1;
    check("mid_rst_digits", digits_out, 32'h0);
    check("mid_rst_valid", 32'(valid_out), 32'h0);
    check("mid_rst_err", 32'(err_out), 32'h0);
    check("mid_rst_multi", 32'(multi_an_out), 32'h0);
    check("mid_rst_update", 32'(update_out), 32'h0);
    check("mid_rst_idx", 32'(update_idx_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_commit(2, 2, 1'b1);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (update_out) begin
        lat = c;
        break;
      end
    end
    check("post_rst_latency", 32'(lat), 32'(SC + 2 + SYNC_LAT));
    #1;
    idle(8 + SYNC_LAT);
    check("post_rst_digits", digits_out, 32'h00000200);
    check("post_rst_valid", 32'(valid_out), 32'h04);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
